// File: rtl/instr_fetch_pkg.sv
// Shared core definitions for the instruction fetch stage.
// Contents: instruction width, NOP encoding, default fetch-queue depth and a
// helper that sizes occupancy counters so they can hold the value DEPTH.
package instr_fetch_pkg;

   localparam int unsigned       InstrW       = 32;
   localparam logic [InstrW-1:0] NopInstr     = 32'h0000_0013;
   localparam int unsigned       DefaultDepth = 2;

   // Counter width able to represent 0..depth inclusive.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel plus the
// fetch-to-decode handshake.
//   master : the fetch stage (drives memReq/memAddr and idValid/idInstr/idPc)
//   slave  : the environment (memory and decode)
interface instr_fetch_if;
   import instr_fetch_pkg::*;

   logic              memReq;
   logic [InstrW-1:0] memAddr;
   logic              memGnt;
   logic              memRvalid;
   logic [InstrW-1:0] memRdata;
   logic              idValid;
   logic [InstrW-1:0] idInstr;
   logic [InstrW-1:0] idPc;
   logic              idReady;

   modport master (
      output memReq, memAddr, idValid, idInstr, idPc,
      input  memGnt, memRvalid, memRdata, idReady
   );

   modport slave (
      input  memReq, memAddr, idValid, idInstr, idPc,
      output memGnt, memRvalid, memRdata, idReady
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a synchronous clear, used for both the address tag
// FIFO and the fetch queue.
// Ports:
//   clk, rstn      clock, synchronous active-low reset (pointers/count only)
//   clr            drop all entries (lower priority than rstn)
//   push, wdata    write; ignored when full unless a pop frees a slot
//   pop            read-advance; ignored when empty
//   rdata          head entry (undefined when empty)
//   count          number of valid entries, 0..DEPTH
module fetch_fifo
   import instr_fetch_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = DefaultDepth
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       clr,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [cnt_width(DEPTH)-1:0] count
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_push, do_pop, full, empty;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CntW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !do_pop) cnt_d = cnt_q + CntW'(1);
      if (!do_push && do_pop) cnt_d = cnt_q - CntW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         cnt_q <= cnt_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (rstn && !clr && do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues in-order word requests to instruction memory,
// tags each with its address, buffers returned words in a fetch queue and
// presents them to decode. A flush drops everything queued and discards the
// responses still owed by memory.
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   pc          fetch address from the PC register
//   flush       jump taken this cycle (new pc valid next cycle)
//   holdFlag    1: PC register holds, 0: PC register advances by 4
//   bus         memory request/response and decode handshake (master side)
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = DefaultDepth
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [InstrW-1:0] pc,
   input  logic              flush,
   output logic              holdFlag,
   instr_fetch_if.master     bus
);

   localparam int unsigned CntW = cnt_width(DEPTH);
   localparam int unsigned SumW = CntW + 2;

   logic [CntW-1:0]     inflight, count, pending;
   logic [CntW-1:0]     discard_q, discard_d;
   logic [SumW-1:0]     used;
   logic [InstrW-1:0]   tag_head;
   logic [2*InstrW-1:0] q_wdata, q_rdata;
   logic                credit, accept, drop, rv_take, tag_pop, q_pop;

   // Every slot is charged from grant until decode pops the word, including
   // responses that will be thrown away after a flush.
   assign used   = SumW'(inflight) + SumW'(count) + SumW'(discard_q);
   assign credit = (used < SumW'(DEPTH));

   assign bus.memReq  = rstn & ~flush & credit;
   assign bus.memAddr = pc & ~InstrW'(3);
   assign accept      = bus.memReq & bus.memGnt;
   assign holdFlag    = ~accept;

   // Stale responses come back first (in-order memory), so they are dropped
   // until discard_q drains. A response with nothing owed is ignored.
   assign drop    = bus.memRvalid & (discard_q != '0);
   assign rv_take = bus.memRvalid & ~drop & (inflight != '0);
   assign tag_pop = rv_take & ~flush;
   assign q_wdata = {tag_head, bus.memRdata};

   assign bus.idValid = rstn & ~flush & (count != '0);
   assign q_pop       = bus.idValid & bus.idReady;
   assign bus.idPc    = q_rdata[2*InstrW-1:InstrW];
   assign bus.idInstr = q_rdata[InstrW-1:0];

   // Bounded by DEPTH, so it fits in CntW bits.
   assign pending = inflight + discard_q;

   always_comb begin
      discard_d = discard_q;
      if (flush) begin
         // A response arriving in the flush cycle is consumed right here.
         discard_d = (bus.memRvalid && pending != '0) ? pending - CntW'(1) : pending;
      end else if (drop) begin
         discard_d = discard_q - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) discard_q <= '0;
      else       discard_q <= discard_d;
   end

   fetch_fifo #(
      .WIDTH (InstrW),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (flush),
      .push  (accept),
      .wdata (bus.memAddr),
      .pop   (tag_pop),
      .rdata (tag_head),
      .count (inflight)
   );

   fetch_fifo #(
      .WIDTH (2 * InstrW),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (flush),
      .push  (tag_pop),
      .wdata (q_wdata),
      .pop   (q_pop),
      .rdata (q_rdata),
      .count (count)
   );

endmodule
